// File: rtl/lvt_mpram_if.sv
// Port bundle for lvt_mpram: NW write ports, NR read ports, flattened per-port vectors.
// Strobe semantics: a port acts when its enable is high at a rising edge; rd_valid[r] is high
// for exactly the cycle after an accepted read and qualifies rd_data[r]; there is no back-pressure.
interface lvt_mpram_if #(
  parameter int DW = 32,
  parameter int AW = 7,
  parameter int NW = 2,
  parameter int NR = 1
);
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic             wr_conflict;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, wr_conflict
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, wr_conflict
  );
endinterface

// File: rtl/lvt_mpram.sv
// NW-write / NR-read RAM from replicated banks plus a live value table and written-valid table.
// Define LVT_BYPASS_EN to forward same-cycle write data to a read of the same address.
module lvt_mpram #(
  parameter int DW = 32,
  parameter int AW = 7,
  parameter int NW = 2,
  parameter int NR = 1
) (
  input  logic        clk,
  input  logic        rst,
  lvt_mpram_if.slave  bus
);

  localparam int LW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] wa [NW];
  logic [DW-1:0] wd [NW];
  logic [AW-1:0] ra [NR];

  for (genvar w = 0; w < NW; w++) begin : g_wr_unpack
    assign wa[w] = bus.wr_addr[w*AW +: AW];
    assign wd[w] = bus.wr_data[w*DW +: DW];
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd_unpack
    assign ra[r] = bus.rd_addr[r*AW +: AW];
  end

  // Bank contents are never reset; the vld table masks stale data instead.
  logic [DW-1:0] bank [NW][NR][DEPTH];

  always_ff @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      for (int r = 0; r < NR; r++) begin
        if (bus.wr_en[w]) bank[w][r][wa[w]] <= wd[w];
      end
    end
  end

  logic [LW-1:0]    lvt [DEPTH];
  logic [DEPTH-1:0] vld;
  logic             conflict_d;
  logic             conflict_q;

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NW; i++) begin
      for (int j = i + 1; j < NW; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] && (wa[i] == wa[j])) conflict_d = 1'b1;
      end
    end
  end

  // Ascending port order: the highest-index writer to an address owns its LVT entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld        <= '0;
      conflict_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) lvt[i] <= '0;
    end else begin
      conflict_q <= conflict_d;
      for (int w = 0; w < NW; w++) begin
        if (bus.wr_en[w]) begin
          lvt[wa[w]] <= LW'(w);
          vld[wa[w]] <= 1'b1;
        end
      end
    end
  end

  logic [DW-1:0] rd_next [NR];

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      rd_next[r] = vld[ra[r]] ? bank[lvt[ra[r]]][r][ra[r]] : '0;
`ifdef LVT_BYPASS_EN
      for (int w = 0; w < NW; w++) begin
        if (bus.wr_en[w] && (wa[w] == ra[r])) rd_next[r] = wd[w];
      end
`endif
    end
  end

  logic [DW-1:0] rd_q [NR];
  logic [NR-1:0] rd_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= '0;
      for (int r = 0; r < NR; r++) rd_q[r] <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      for (int r = 0; r < NR; r++) begin
        if (bus.rd_en[r]) rd_q[r] <= rd_next[r];
      end
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd_pack
    assign bus.rd_data[r*DW +: DW] = rd_q[r];
  end

  assign bus.rd_valid    = rd_valid_q;
  assign bus.wr_conflict = conflict_q;

endmodule
